input_rle_encoder: RTL and testbench



---
 rtl/input_rle_encoder_pkg.sv | 17 +
 rtl/input_rle_encoder_glitch_filter.sv | 50 +++++
 rtl/input_rle_encoder.sv | 90 +++++++++
 tb/tb_input_rle_encoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/input_rle_encoder_pkg.sv
// Shared delay-line definitions: default run-length width and the token layout
// (level bit above the length field) used by the encoder and the delay-line storage.
package input_rle_encoder_pkg;

    localparam int COUNT_W_DEFAULT = 16;

    typedef struct packed {
        logic                       level;
        logic [COUNT_W_DEFAULT-1:0] len;
    } run_token_t;

    // Packed token width for an arbitrary run-length width: {level, len}.
    function automatic int token_width(input int count_w);
        return count_w + 1;
    endfunction

endpackage

// File: rtl/input_rle_encoder_glitch_filter.sv
// Synchroniser chain plus consecutive-sample glitch filter for one asynchronous board input.
// Asserts flip for one cycle when the filtered level is about to change.
module input_rle_encoder_glitch_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic n_reset,
    input  logic async_in,
    output logic filt_out,
    output logic flip
);

    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FW-1:0] F_LAST = FW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FW-1:0]          f_q;
    logic                   filt_q;
    logic                   s;

    assign s        = sync_q[SYNC_STAGES-1];
    assign filt_out = filt_q;
    assign flip     = (s != filt_q) && (f_q == F_LAST);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
        end
    end

    // The counter only advances while s disagrees with the filtered level,
    // so any agreeing sample restarts the qualification window.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            f_q    <= '0;
            filt_q <= 1'b0;
        end else if (s == filt_q) begin
            f_q <= '0;
        end else if (f_q == F_LAST) begin
            filt_q <= s;
            f_q    <= '0;
        end else begin
            f_q <= f_q + 1'b1;
        end
    end

endmodule

// File: rtl/input_rle_encoder.sv
// Front end for the delay line: synchronise and de-glitch the board input, then
// compress the clean level into (level, length) run tokens on a valid/ready stream.
module input_rle_encoder
    import input_rle_encoder_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int COUNT_W     = COUNT_W_DEFAULT
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               in,
    output logic               filt_out,
    output logic               run_level,
    output logic [COUNT_W-1:0] run_len,
    output logic               run_valid,
    input  logic               run_ready,
    output logic               overflow
);

    localparam int TOKEN_W = token_width(COUNT_W);
    localparam logic [COUNT_W-1:0] RUN_MAX = '1;

    logic               flip;
    logic               emit;
    logic [COUNT_W-1:0] cnt_q;
    logic [COUNT_W-1:0] cnt_d;
    logic [TOKEN_W-1:0] emit_token;
    logic [TOKEN_W-1:0] hold_q;
    logic               valid_q;
    logic               overflow_q;

    input_rle_encoder_glitch_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_glitch_filter (
        .clk     (clk),
        .n_reset (n_reset),
        .async_in(in),
        .filt_out(filt_out),
        .flip    (flip)
    );

    // A flip closes the run at the old level; saturation splits a long run
    // into MAX-length pieces of the same level.
    always_comb begin
        emit       = 1'b0;
        cnt_d      = cnt_q + 1'b1;
        emit_token = {filt_out, cnt_q};
        if (flip || (cnt_q == RUN_MAX)) begin
            emit  = 1'b1;
            cnt_d = COUNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Handshake: a token transfers on a cycle where run_valid && run_ready;
    // while run_valid && !run_ready the token is held stable. The single-entry
    // holder accepts a new token whenever it is empty or being drained this
    // cycle; otherwise the new token is lost and overflow latches.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            hold_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else if (emit) begin
            if (!valid_q || run_ready) begin
                hold_q  <= emit_token;
                valid_q <= 1'b1;
            end else begin
                overflow_q <= 1'b1;
            end
        end else if (valid_q && run_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign run_valid = valid_q;
    assign run_level = hold_q[COUNT_W];
    assign run_len   = hold_q[COUNT_W-1:0];
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_input_rle_encoder.sv
// Directed bench for input_rle_encoder (COUNT_W=8 so saturation is reachable quickly).
module tb_input_rle_encoder;

    localparam int COUNT_W = 8;

    logic               clk;
    logic               n_reset;
    logic               in;
    logic               filt_out;
    logic               run_level;
    logic [COUNT_W-1:0] run_len;
    logic               run_valid;
    logic               run_ready;
    logic               overflow;

    int tests_run;
    int tests_failed;

    input_rle_encoder #(
        .SYNC_STAGES(2),
        .FILTER_LEN (4),
        .COUNT_W    (COUNT_W)
    ) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .in       (in),
        .filt_out (filt_out),
        .run_level(run_level),
        .run_len  (run_len),
        .run_valid(run_valid),
        .run_ready(run_ready),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges; afterwards we sit 1 time unit past the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_filt"},  32'(filt_out),  32'd0);
        check({tag, "_valid"}, 32'(run_valid), 32'd0);
    endtask

    task automatic check_token(input string tag, input logic lvl, input int len);
        check({tag, "_valid"}, 32'(run_valid), 32'd1);
        check({tag, "_level"}, 32'(run_level), 32'(lvl));
        check({tag, "_len"},   32'(run_len),   32'(len));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_filt"},  32'(filt_out),  32'd0);
        check({tag, "_valid"}, 32'(run_valid), 32'd0);
        check({tag, "_level"}, 32'(run_level), 32'd0);
        check({tag, "_len"},   32'(run_len),   32'd0);
        check({tag, "_ovf"},   32'(overflow),  32'd0);
    endtask

    // Reset is released 1 unit after an edge; the next edge is edge 1 after release.
    task automatic do_reset(input logic ready);
        n_reset   = 1'b0;
        in        = 1'b0;
        run_ready = ready;
        tick(2);
        n_reset = 1'b1;
    endtask

    always @(negedge clk) begin
        if (n_reset && run_valid) begin
            tests_run++;
            assert (run_len != '0) else begin
                tests_failed++;
                $error("FAIL nonzero_len: observed %0d expected nonzero", run_len);
            end
        end
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        n_reset      = 1'b0;
        in           = 1'b0;
        run_ready    = 1'b1;

        // Reset state and first run
        n_reset = 1'b0;
        tick(2);
        check_all_zero("reset");
        n_reset = 1'b1;
        tick(20);
        check_idle("quiet20");
        in = 1'b1;
        tick(5);
        check_idle("edge25");
        tick(1);
        check("rise_filt", 32'(filt_out), 32'd1);
        check_token("first_tok", 1'b0, 25);
        tick(1);
        check("first_drain", 32'(run_valid), 32'd0);

        // Glitch rejection: two 3-cycle pulses, then one 4-cycle pulse
        do_reset(1'b1);
        tick(10);
        in = 1'b1;
        tick(3);
        in = 1'b0;
        tick(5);
        in = 1'b1;
        tick(3);
        in = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick(1);
            check_idle("glitch3");
        end
        in = 1'b1;
        tick(4);
        in = 1'b0;
        tick(1);
        check_idle("pulse4_pre");
        tick(1);
        check("pulse4_filt_hi", 32'(filt_out), 32'd1);
        check_token("pulse4_tok0", 1'b0, 35);
        tick(3);
        check("pulse4_drain", 32'(run_valid), 32'd0);
        tick(1);
        check("pulse4_filt_lo", 32'(filt_out), 32'd0);
        check_token("pulse4_tok1", 1'b1, 4);

        // Saturation split at 255
        do_reset(1'b1);
        tick(255);
        check("sat_pre", 32'(run_valid), 32'd0);
        tick(1);
        check_token("sat_tok0", 1'b0, 255);
        tick(1);
        check("sat_drain", 32'(run_valid), 32'd0);
        tick(254);
        check_token("sat_tok1", 1'b0, 255);
        tick(89);
        check_idle("sat600");
        in = 1'b1;
        tick(6);
        check("sat_filt", 32'(filt_out), 32'd1);
        check_token("sat_residual", 1'b0, 95);

        // Backpressure: second token dropped, overflow sticky
        do_reset(1'b0);
        tick(10);
        in = 1'b1;
        tick(6);
        check_token("bp_tok0", 1'b0, 15);
        check("bp_ovf0", 32'(overflow), 32'd0);
        tick(4);
        in = 1'b0;
        tick(5);
        check_token("bp_hold", 1'b0, 15);
        tick(1);
        check("bp_filt", 32'(filt_out), 32'd0);
        check_token("bp_stable", 1'b0, 15);
        check("bp_ovf1", 32'(overflow), 32'd1);
        tick(1);
        run_ready = 1'b1;
        tick(1);
        check("bp_drain", 32'(run_valid), 32'd0);
        check("bp_ovf_sticky", 32'(overflow), 32'd1);

        // Simultaneous accept and emit: no bubble, no overflow
        do_reset(1'b0);
        tick(10);
        in = 1'b1;
        tick(6);
        check_token("sim_tok0", 1'b0, 15);
        tick(4);
        in = 1'b0;
        tick(5);
        run_ready = 1'b1;
        tick(1);
        check_token("sim_tok1", 1'b1, 10);
        check("sim_ovf", 32'(overflow), 32'd0);
        run_ready = 1'b0;
        tick(2);
        check_token("sim_hold", 1'b1, 10);

        // Asynchronous reset mid-run with a token held
        #2;
        n_reset = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick(1);
        n_reset   = 1'b1;
        run_ready = 1'b1;
        tick(10);
        check_idle("restart_quiet");
        in = 1'b1;
        tick(6);
        check_token("restart_tok", 1'b0, 15);
        check("restart_ovf", 32'(overflow), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
